// File: rtl/arith_pkg.sv
// arith_pkg: shared constants and types for the arithmetic sequencer.
//   ARITH_WIDTH_DEF  default operand width
//   ARITH_ADD/SUB/MUL/DIV  operation codes (2-bit)
//   arith_state_e    sequencer FSM states
package arith_pkg;

    localparam int ARITH_WIDTH_DEF = 16;

    localparam logic [1:0] ARITH_ADD = 2'b00;
    localparam logic [1:0] ARITH_SUB = 2'b01;
    localparam logic [1:0] ARITH_MUL = 2'b10;
    localparam logic [1:0] ARITH_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

endpackage

// File: rtl/arith_div_iter.sv
// arith_div_iter: one restoring-division step (combinational).
// Only compiled when ARITH_DIV_EN is defined.
//   rem      partial remainder in
//   quo      dividend bits still to shift in (MSB first) / quotient so far
//   divisor  divisor (non-zero)
//   rem_nxt  partial remainder out
//   quo_nxt  quo shifted left with the new quotient bit in the LSB
`ifdef ARITH_DIV_EN
module arith_div_iter #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Bring down the next dividend bit, then try subtracting the divisor.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        if (shifted < {1'b0, divisor}) begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end else begin
            // Remainder is always < divisor, so it fits in WIDTH bits.
            rem_nxt = diff[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule
`endif

// File: rtl/arith_seq_unit.sv
// arith_seq_unit: sequential unsigned add/sub/mul/div unit with a
// valid/ready request port and a valid/ready result port.
//   clk, rst_arith (async, active-low)
//   in_valid/in_ready, op, a, b       request (in_ready high only in IDLE)
//   out_valid/out_ready               result handshake
//   result_lo/result_hi               low/high result halves
//   flag_carry/flag_zero/flag_err     status flags
// Add/sub and error cases complete in one cycle; mul (shift-add) and div
// (restoring) take WIDTH iterations in CALC.
// Build option: define ARITH_DIV_EN to include the divider; without it
// op 11 returns zero with flag_err set after one cycle.
module arith_seq_unit
    import arith_pkg::*;
#(
    parameter int WIDTH    = ARITH_WIDTH_DEF,
    parameter int OP_WIDTH = 2
) (
    input  logic                clk,
    input  logic                rst_arith,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_WIDTH-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result_lo,
    output logic [WIDTH-1:0]    result_hi,
    output logic                flag_carry,
    output logic                flag_zero,
    output logic                flag_err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(ARITH_ADD);
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(ARITH_SUB);
    localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(ARITH_MUL);
`ifdef ARITH_DIV_EN
    localparam logic [OP_WIDTH-1:0] OP_DIV = OP_WIDTH'(ARITH_DIV);
`endif

    arith_state_e      state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  mcand;     // multiplicand or divisor
    logic [WIDTH-1:0]  p_hi;      // product high half / partial remainder
    logic [WIDTH-1:0]  p_lo;      // multiplier->product low / dividend->quotient
    logic              accept;
    logic              is_calc;

    // Single-cycle results
    logic [WIDTH-1:0]  l_lo, l_hi;
    logic              l_carry, l_err;

    // Iteration step results
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_hi, mul_lo;
    logic [WIDTH-1:0]  s_hi, s_lo;

    assign accept = in_valid && in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_arith) begin
        if (!rst_arith) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = is_calc ? ST_CALC : ST_DONE;
            // cnt==1 means this edge takes the counter to 0: last iteration.
            ST_CALC: if (cnt == CW'(1)) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // ---------------- request decode ----------------
    always_comb begin
        is_calc = (op == OP_MUL);
`ifdef ARITH_DIV_EN
        if (op == OP_DIV && b != '0) is_calc = 1'b1;
`endif
    end

    always_comb begin
        l_lo    = '0;
        l_hi    = '0;
        l_carry = 1'b0;
        l_err   = 1'b0;
        if (op == OP_ADD) begin
            {l_carry, l_lo} = {1'b0, a} + {1'b0, b};
        end else if (op == OP_SUB) begin
            l_lo    = a - b;
            l_carry = (a < b);
`ifdef ARITH_DIV_EN
        end else if (op == OP_DIV) begin
            // Only reached with b==0; non-zero divisors go to CALC.
            l_lo  = '1;
            l_hi  = a;
            l_err = 1'b1;
`endif
        end else begin
            l_err = 1'b1;
        end
    end

    // ---------------- iteration step ----------------
    // Shift-add: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole product right by one.
    assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], p_lo[WIDTH-1:1]};

`ifdef ARITH_DIV_EN
    logic             is_div;
    logic [WIDTH-1:0] div_rem, div_quo;

    arith_div_iter #(.WIDTH(WIDTH)) u_div (
        .rem     (p_hi),
        .quo     (p_lo),
        .divisor (mcand),
        .rem_nxt (div_rem),
        .quo_nxt (div_quo)
    );

    assign s_hi = is_div ? div_rem : mul_hi;
    assign s_lo = is_div ? div_quo : mul_lo;
`else
    assign s_hi = mul_hi;
    assign s_lo = mul_lo;
`endif

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_arith) begin
        if (!rst_arith) begin
            cnt        <= '0;
            mcand      <= '0;
            p_hi       <= '0;
            p_lo       <= '0;
            result_lo  <= '0;
            result_hi  <= '0;
            flag_carry <= 1'b0;
            flag_zero  <= 1'b0;
            flag_err   <= 1'b0;
        end else if (accept) begin
            if (is_calc) begin
                mcand <= b;
                p_hi  <= '0;
                p_lo  <= a;
                cnt   <= CW'(WIDTH);
            end else begin
                result_lo  <= l_lo;
                result_hi  <= l_hi;
                flag_carry <= l_carry;
                flag_err   <= l_err;
                flag_zero  <= (l_lo == '0) && (l_hi == '0);
            end
        end else if (state == ST_CALC) begin
            p_hi <= s_hi;
            p_lo <= s_lo;
            cnt  <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                result_lo  <= s_lo;
                result_hi  <= s_hi;
                flag_carry <= 1'b0;
                flag_err   <= 1'b0;
                flag_zero  <= (s_lo == '0) && (s_hi == '0);
            end
        end
    end

`ifdef ARITH_DIV_EN
    always_ff @(posedge clk or negedge rst_arith) begin
        if (!rst_arith)  is_div <= 1'b0;
        else if (accept) is_div <= (op == OP_DIV);
    end
`endif

endmodule

// File: tb/tb_arith_seq_unit.sv
// tb_arith_seq_unit: directed self-checking bench for arith_seq_unit
// (WIDTH=16). Expected values are hand-computed constants.
module tb_arith_seq_unit;

    logic        clk = 1'b0;
    logic        rst_arith;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result_lo, result_hi;
    logic        flag_carry, flag_zero, flag_err;

    int n_cmp  = 0;
    int n_fail = 0;

    arith_seq_unit #(.WIDTH(16), .OP_WIDTH(2)) dut (
        .clk        (clk),
        .rst_arith  (rst_arith),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero),
        .flag_err   (flag_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller is at #1 after a posedge with in_ready high. Issues one request,
    // scrambles the operands after acceptance, waits for out_valid and checks
    // the latency (accept edge counts as 1).
    task automatic run(input string tag, input logic [1:0] o, input logic [15:0] x,
                       input logic [15:0] y, input int exp_lat);
        int lat;
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; op = ~o; a = 16'($urandom); b = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
    endtask

    task automatic check_res(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                             input logic c, input logic z, input logic e);
        check({tag, " result_lo"}, result_lo, lo);
        check({tag, " result_hi"}, result_hi, hi);
        check({tag, " flags c/z/e"}, {flag_carry, flag_zero, flag_err}, {c, z, e});
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " post-release valid/ready"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        bit saw_valid;
        rst_arith = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; out_ready = 1'b0;

        // Reset state; a request offered during reset must not be taken.
        @(posedge clk); #1;
        in_valid = 1'b1; op = 2'b00; a = 16'h0001; b = 16'h0002;
        @(posedge clk); #1;
        check("reset ready/valid", {in_ready, out_valid}, 2'b10);
        check("reset results", {result_hi, result_lo}, 32'h0);
        check("reset flags", {flag_carry, flag_zero, flag_err}, 3'b000);
        in_valid = 1'b0;
        rst_arith = 1'b1;
        @(posedge clk); #1;
        check("after reset idle", {in_ready, out_valid}, 2'b10);

        // Add with carry-out and zero result
        run("add ffff+1", 2'b00, 16'hFFFF, 16'h0001, 1);
        check_res("add ffff+1", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
        release_out("add ffff+1");

        // Sub with borrow
        run("sub 3-5", 2'b01, 16'h0003, 16'h0005, 1);
        check_res("sub 3-5", 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0);
        release_out("sub 3-5");

        // Plain add, no carry
        run("add 1234+1111", 2'b00, 16'h1234, 16'h1111, 1);
        check_res("add 1234+1111", 16'h2345, 16'h0000, 1'b0, 1'b0, 1'b0);
        release_out("add 1234+1111");

        // Sub equal operands -> zero, no borrow
        run("sub 5-5", 2'b01, 16'h0005, 16'h0005, 1);
        check_res("sub 5-5", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        release_out("sub 5-5");

        // Mul
        run("mul 1234*10", 2'b10, 16'h1234, 16'h0010, 17);
        check_res("mul 1234*10", 16'h2340, 16'h0001, 1'b0, 1'b0, 1'b0);
        release_out("mul 1234*10");

        run("mul ffff*ffff", 2'b10, 16'hFFFF, 16'hFFFF, 17);
        check_res("mul ffff*ffff", 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        release_out("mul ffff*ffff");

`ifdef ARITH_DIV_EN
        run("div 100/7", 2'b11, 16'd100, 16'd7, 17);
        check_res("div 100/7", 16'd14, 16'd2, 1'b0, 1'b0, 1'b0);
        release_out("div 100/7");

        run("div 5/0", 2'b11, 16'd5, 16'd0, 1);
        check_res("div 5/0", 16'hFFFF, 16'h0005, 1'b0, 1'b0, 1'b1);
        release_out("div 5/0");
`else
        run("op11 no div", 2'b11, 16'd100, 16'd7, 1);
        check_res("op11 no div", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        release_out("op11 no div");
`endif

        // Backpressure: result held, in_valid ignored while DONE
        run("bp add 2+3", 2'b00, 16'h0002, 16'h0003, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; op = 2'b01; a = 16'h0009; b = 16'h0009;
            @(posedge clk); #1;
            check("bp hold valid/ready", {out_valid, in_ready}, 2'b10);
            check("bp hold result", {result_hi, result_lo}, 32'h0000_0005);
        end
        in_valid = 1'b0;
        release_out("bp add 2+3");

        // Reset during mul CALC cycle 8
        in_valid = 1'b1; op = 2'b10; a = 16'h1234; b = 16'h0010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("mid-mul still busy", {out_valid, in_ready}, 2'b00);
        rst_arith = 1'b0;
        #1;
        check("abort ready/valid", {in_ready, out_valid}, 2'b10);
        check("abort results", {result_hi, result_lo}, 32'h0);
        check("abort flags", {flag_carry, flag_zero, flag_err}, 3'b000);
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
            if (i == 2) rst_arith = 1'b1;
        end
        check("no valid after abort", saw_valid, 1'b0);

        run("post-reset add 7+8", 2'b00, 16'h0007, 16'h0008, 1);
        check_res("post-reset add 7+8", 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0);
        release_out("post-reset add 7+8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
